div_request_sequencer: RTL

//  Upstream feeder for int_divider: queues division requests arriving on a valid/ready stream.

---
 rtl/div_request_sequencer_if.sv | 31 +++
 rtl/div_request_sequencer.sv | 107 ++++++++++
 2 files changed

// File: rtl/div_request_sequencer_if.sv
// div_request_sequencer_if: request, divider and response bundles of div_request_sequencer
// slave = sequencer side, master = source/divider/consumer side.
// req_*: valid/ready request stream; div_*: start pulse, held operands, done/result;
// rsp_*: valid/ready response stream with quotient, remainder, div-by-zero flag.
interface div_request_sequencer_if #(parameter int WIDTH = 16);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_dividend;
  logic [WIDTH-1:0] req_divisor;
  logic             div_start;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;
  logic             div_done;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_quotient;
  logic [WIDTH-1:0] rsp_remainder;
  logic             rsp_div_by_zero;
  modport slave (
    input  req_valid, req_dividend, req_divisor, div_quotient, div_remainder, div_done, rsp_ready,
    output req_ready, div_start, div_dividend, div_divisor, rsp_valid, rsp_quotient, rsp_remainder,
           rsp_div_by_zero
  );
  modport master (
    output req_valid, req_dividend, req_divisor, div_quotient, div_remainder, div_done, rsp_ready,
    input  req_ready, div_start, div_dividend, div_divisor, rsp_valid, rsp_quotient, rsp_remainder,
           rsp_div_by_zero
  );
endinterface

// File: rtl/div_request_sequencer.sv
// div_request_sequencer: queues divide requests, issues them one at a time to int_divider, returns results in order
// Ports: clk, rst (async active-high), bus (div_request_sequencer_if.slave),
// fifo_count (queued requests 0..DEPTH), busy (not idle or queue non-empty).
// Optional feature macro DIV_ZERO_BYPASS_EN: zero divisors answered locally without the divider.
module div_request_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  div_request_sequencer_if.slave   bus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t             state_q;
  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [AW:0]        count_q, count_d;
  logic               push, pop;
  logic [WIDTH-1:0]   head_a, head_b;
  logic               start_q, rv_q;
  logic [WIDTH-1:0]   dvd_q, dvs_q, q_q, r_q;
  assign {head_a, head_b} = mem_q[rd_q];
  assign bus.req_ready = count_q != (AW+1)'(DEPTH);
  assign push = bus.req_valid && bus.req_ready;
  assign pop = state_q == IDLE && count_q != '0;
  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  assign fifo_count = count_q;
  assign busy = state_q != IDLE || count_q != '0;
  assign bus.div_start = start_q;
  assign bus.div_dividend = dvd_q;
  assign bus.div_divisor = dvs_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_quotient = q_q;
  assign bus.rsp_remainder = r_q;
`ifdef DIV_ZERO_BYPASS_EN
  logic dbz_q;
  assign bus.rsp_div_by_zero = dbz_q;
`else
  assign bus.rsp_div_by_zero = 1'b0;
`endif
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {bus.req_dividend, bus.req_divisor};
  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      count_q <= count_d;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      dvd_q <= '0;
      dvs_q <= '0;
      q_q <= '0;
      r_q <= '0;
      rv_q <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
      dbz_q <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: if (pop) begin
          dvd_q <= head_a;
          dvs_q <= head_b;
`ifdef DIV_ZERO_BYPASS_EN
          if (head_b == '0) begin
            q_q <= '1;
            r_q <= head_a;
            dbz_q <= 1'b1;
            rv_q <= 1'b1;
            state_q <= HOLD;
          end else begin
            start_q <= 1'b1;
            state_q <= ISSUE;
          end
`else
          start_q <= 1'b1;
          state_q <= ISSUE;
`endif
        end
        ISSUE: state_q <= WAIT;
        WAIT: if (bus.div_done) begin
          q_q <= bus.div_quotient;
          r_q <= bus.div_remainder;
          rv_q <= 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
          dbz_q <= 1'b0;
`endif
          state_q <= HOLD;
        end
        HOLD: if (bus.rsp_ready) begin
          rv_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
endmodule
